// File: rtl/conv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// conv_seq_ctrl
//
// Sequencing controller for a 2-channel 4x4 (32-tap) 3D convolution. A single
// multiply-accumulate unit is time-shared across the 32 taps of a frame. Each
// accepted IFM element is multiplied by the weight of its tap position and
// added into an unsigned accumulator. When the frame closes, the sum is
// presented on a registered valid/ready result port.
//
// Configuration macro: CONV_WGT_WR_EN
//   defined   : weight write port present; 32 x DW weight register file,
//               reset to 0, writable only while IDLE.
//   undefined : weights are a fixed constant table; no weight registers.
//
// Ports:
//   clk       in   1    clock, rising edge
//   rst       in   1    asynchronous reset, active high
//   s_valid   in   1    IFM element valid
//   s_ready   out  1    controller can accept an element (IDLE / ACC)
//   s_data    in   DW   IFM element, ch0 row0 col0 .. ch1 row3 col3
//   s_last    in   1    final element of frame
//   m_valid   out  1    OFM result valid (held until m_ready)
//   m_ready   in   1    downstream accepts the result
//   m_data    out  OW   OFM result
//   wgt_we    in   1    weight write strobe        (CONV_WGT_WR_EN only)
//   wgt_addr  in   AW   weight index 0..N_TAP-1    (CONV_WGT_WR_EN only)
//   wgt_data  in   DW   weight value               (CONV_WGT_WR_EN only)
//   busy      out  1    frame in progress (state != IDLE)
//   err_len   out  1    one-cycle pulse: frame length error
// -----------------------------------------------------------------------------
module conv_seq_ctrl #(
   parameter int N_TAP = 32,
   parameter int DW    = 4,
   parameter int OW    = 13,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   input  logic          s_last,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [OW-1:0] m_data,
`ifdef CONV_WGT_WR_EN
   input  logic          wgt_we,
   input  logic [AW-1:0] wgt_addr,
   input  logic [DW-1:0] wgt_data,
`endif
   output logic          busy,
   output logic          err_len
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t          state;
   logic [AW-1:0]   idx;        // tap index of the next element
   logic [OW-1:0]   acc;        // running sum of the current frame

   logic            beat;
   logic            at_last_tap;
   logic            frame_end;
   logic [AW-1:0]   rd_addr;
   logic [DW-1:0]   wsel;
   logic [2*DW-1:0] prod;
   logic [OW-1:0]   acc_next;

   // --------------------------------------------------------------------------
   // Weight storage
   // --------------------------------------------------------------------------
`ifdef CONV_WGT_WR_EN
   logic [DW-1:0] wgt [N_TAP];

   // NOTE: this small register file is reset explicitly (unlike a RAM macro)
   // so the convolution result after reset is defined rather than X.
   // Writes are only honoured in IDLE, keeping weights frozen during a frame;
   // a write coinciding with a first beat lands after that beat has read W[0].
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_TAP; i++) begin
            wgt[i] <= '0;
         end
      end else if (wgt_we && (state == IDLE)) begin
         wgt[wgt_addr] <= wgt_data;
      end
   end

   assign wsel = wgt[rd_addr];
`else
   localparam logic [DW-1:0] DEF_WGT [N_TAP] = '{
      4'd6,  4'd14, 4'd13, 4'd10, 4'd10, 4'd14, 4'd3,  4'd4,
      4'd0,  4'd6,  4'd7,  4'd9,  4'd11, 4'd12, 4'd6,  4'd3,
      4'd2,  4'd1,  4'd5,  4'd8,  4'd7,  4'd13, 4'd1,  4'd8,
      4'd7,  4'd12, 4'd13, 4'd10, 4'd10, 4'd9,  4'd7,  4'd7
   };

   assign wsel = DEF_WGT[rd_addr];
`endif

   // --------------------------------------------------------------------------
   // Datapath: one shared multiplier and adder
   // --------------------------------------------------------------------------
   assign beat = s_valid && s_ready;

   // The element consumed in IDLE is always tap 0 of a new frame.
   assign rd_addr = (state == IDLE) ? '0 : idx;

   // The frame closes on s_last, or on the final tap even without s_last.
   assign at_last_tap = (state == ACC) && (idx == AW'(N_TAP - 1));
   assign frame_end   = beat && (s_last || at_last_tap);

   // NOTE: every signal driven here gets a default value first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      prod     = '0;
      acc_next = '0;
      prod     = {{DW{1'b0}}, s_data} * {{DW{1'b0}}, wsel};
      // A frame's first product replaces, rather than adds to, the old sum.
      acc_next = ((state == IDLE) ? '0 : acc) + {{(OW - 2*DW){1'b0}}, prod};
   end

   // --------------------------------------------------------------------------
   // Control FSM with registered outputs
   // --------------------------------------------------------------------------
   // NOTE: state and outputs use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         acc     <= '0;
         s_ready <= 1'b0;
         m_valid <= 1'b0;
         m_data  <= '0;
         busy    <= 1'b0;
         err_len <= 1'b0;
      end else begin
         err_len <= 1'b0;
         case (state)
            IDLE, ACC: begin
               s_ready <= 1'b1;
               if (beat) begin
                  acc  <= acc_next;
                  busy <= 1'b1;
                  if (frame_end) begin
                     state   <= OUT;
                     idx     <= '0;
                     s_ready <= 1'b0;
                     m_valid <= 1'b1;
                     m_data  <= acc_next;
                     // Short frame: s_last before the last tap.
                     // Long frame: last tap reached without s_last.
                     err_len <= s_last ^ at_last_tap;
                  end else begin
                     state <= ACC;
                     idx   <= idx + AW'(1);
                  end
               end
            end

            OUT: begin
               if (m_ready) begin
                  state   <= IDLE;
                  acc     <= '0;
                  s_ready <= 1'b1;
                  m_valid <= 1'b0;
                  busy    <= 1'b0;
               end
            end

            default: begin
               state   <= IDLE;
               idx     <= '0;
               acc     <= '0;
               s_ready <= 1'b1;
               m_valid <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_seq_ctrl
//
// Directed bench for conv_seq_ctrl. Expected results are computed from a
// tap-by-tap reference model as elements are driven and queued in a
// scoreboard; a negedge monitor pops and compares them when the result port
// handshakes. Builds with or without CONV_WGT_WR_EN.
// -----------------------------------------------------------------------------
module tb_conv_seq_ctrl;

   localparam int N_TAP = 32;
   localparam int DW    = 4;
   localparam int OW    = 13;
   localparam int AW    = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic          m_valid;
   logic          m_ready;
   logic [OW-1:0] m_data;
   logic          busy;
   logic          err_len;
`ifdef CONV_WGT_WR_EN
   logic          wgt_we;
   logic [AW-1:0] wgt_addr;
   logic [DW-1:0] wgt_data;
`endif

   conv_seq_ctrl #(.N_TAP(N_TAP), .DW(DW), .OW(OW), .AW(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .s_last   (s_last),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
`ifdef CONV_WGT_WR_EN
      .wgt_we   (wgt_we),
      .wgt_addr (wgt_addr),
      .wgt_data (wgt_data),
`endif
      .busy     (busy),
      .err_len  (err_len)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Counters, reference model and scoreboard
   // ---------------------------------------------------------------------------
   int checks = 0;
   int errors = 0;

   typedef struct {
      int data;
      int err;
   } exp_t;

   exp_t sbq[$];

   int def_w [N_TAP] = '{6, 14, 13, 10, 10, 14, 3, 4, 0, 6, 7, 9, 11, 12, 6, 3,
                         2, 1, 5, 8, 7, 13, 1, 8, 7, 12, 13, 10, 10, 9, 7, 7};
   int wm [N_TAP];          // weights the DUT is expected to be using
   int idx_m = 0;
   int acc_m = 0;
   logic [DW-1:0] fd [64];  // element values of the frame being driven
   bit mv_q = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      idx_m = 0;
      acc_m = 0;
      for (int i = 0; i < N_TAP; i++) begin
`ifdef CONV_WGT_WR_EN
         wm[i] = 0;
`else
         wm[i] = def_w[i];
`endif
      end
   endtask

   task automatic model_beat(input int d, input bit last);
      bit top;
      top   = (idx_m == N_TAP - 1);
      acc_m = acc_m + d * wm[idx_m];
      if (last || top) begin
         sbq.push_back('{acc_m, int'(last ^ top)});
         acc_m = 0;
         idx_m = 0;
      end else begin
         idx_m++;
      end
   endtask

   // Drives fd[first .. first+n-1]; s_last on element last_at (-1 = none).
   // Called just after a rising edge; returns just after the last beat's edge.
   task automatic run_beats(input int first, input int n, input int last_at, output int stall0);
      stall0 = 0;
      for (int i = first; i < first + n; i++) begin
         int waits;
         waits   = 0;
         s_valid = 1'b1;
         s_data  = fd[i];
         s_last  = (i == last_at);
         forever begin
            @(negedge clk);
            if (s_ready) break;
            waits++;
            if (waits > 200) begin
               $display("FAIL beat_timeout observed=%0d expected=<200 (element %0d)", waits, i);
               $fatal(1, "s_ready never asserted");
            end
         end
         if (i == first) stall0 = waits;
         @(posedge clk);
         #1;
         model_beat(int'(fd[i]), s_last);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic fill(input int n, input int mode, input int val);
      for (int i = 0; i < n; i++) begin
         fd[i] = (mode == 0) ? DW'(val) : DW'($urandom_range(0, 15));
      end
   endtask

   // Waits for every queued result to be consumed and the FSM to go idle.
   task automatic drain(input string tag);
      int cyc;
      cyc = 0;
      while ((sbq.size() != 0 || busy) && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_drain_timeout"}, (cyc < 300) ? 1 : 0, 1);
      @(posedge clk);
      #1;
   endtask

`ifdef CONV_WGT_WR_EN
   // Write issued just after an edge; takes effect at the next edge.
   task automatic wr_w(input int a, input int v, input bit expect_taken);
      wgt_we   = 1'b1;
      wgt_addr = AW'(a);
      wgt_data = DW'(v);
      @(posedge clk);
      #1;
      wgt_we = 1'b0;
      if (expect_taken) wm[a] = v;
   endtask

   task automatic wr_all(input int mode, input int val);
      for (int i = 0; i < N_TAP; i++) begin
         wr_w(i, (mode == 0) ? val : int'($urandom_range(0, 15)), 1'b1);
      end
   endtask
`endif

   // ---------------------------------------------------------------------------
   // Result monitor: err_len checked on the first OUT cycle, data on handshake
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      if (rst) begin
         mv_q = 1'b0;
      end else begin
         if (m_valid && !mv_q) begin
            if (sbq.size() == 0) chk("unexpected_result", 1, 0);
            else                 chk("err_len_pulse", err_len, sbq[0].err);
         end else begin
            chk("err_len_quiet", err_len, 0);
         end
         if (m_valid && m_ready) begin
            if (sbq.size() == 0) begin
               chk("result_without_expect", 1, 0);
            end else begin
               chk("m_data", m_data, sbq[0].data);
               void'(sbq.pop_front());
            end
         end
         mv_q = m_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      int st;
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      m_ready = 1'b1;
`ifdef CONV_WGT_WR_EN
      wgt_we   = 1'b0;
      wgt_addr = '0;
      wgt_data = '0;
`endif
      model_reset();

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data",  m_data,  0);
      chk("rst_busy",    busy,    0);
      chk("rst_err_len", err_len, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_s_ready", s_ready, 1);

      // Basic sum: all ones, s_last on element 32
`ifdef CONV_WGT_WR_EN
      wr_all(0, 1);
`endif
      fill(32, 0, 1);
      run_beats(0, 32, 31, st);
      @(negedge clk);
      chk("latency_m_valid", m_valid, 1);
      chk("out_s_ready", s_ready, 0);
      drain("basic");

      // Max value
`ifdef CONV_WGT_WR_EN
      wr_all(0, 15);
`endif
      fill(32, 0, 15);
      run_beats(0, 32, 31, st);
      drain("max");

      // Short frame: s_last on element 10
`ifdef CONV_WGT_WR_EN
      wr_all(0, 3);
`endif
      fill(10, 0, 2);
      run_beats(0, 10, 9, st);
      drain("short");
      chk("short_idle_busy", busy, 0);
      chk("short_idle_s_ready", s_ready, 1);

      // Single-element frame (s_last on the first beat)
      fill(1, 1, 0);
      run_beats(0, 1, 0, st);
      drain("single");

      // Long frame: 33 elements, no s_last until element 33
`ifdef CONV_WGT_WR_EN
      wr_all(1, 0);
`endif
      fill(33, 1, 0);
      run_beats(0, 33, 32, st);
      drain("long");

      // Backpressure: result held 5 cycles with an element offered
      m_ready = 1'b0;
      fill(5, 1, 0);
      run_beats(0, 5, 4, st);
      fill(32, 1, 0);
      s_valid = 1'b1;
      s_data  = fd[0];
      s_last  = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_m_valid", m_valid, 1);
         chk("bp_m_data",  m_data,  sbq[0].data);
         chk("bp_s_ready", s_ready, 0);
         chk("bp_busy",    busy,    1);
      end
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hs_m_valid", m_valid, 0);
      chk("hs_busy",    busy,    0);
      chk("hs_s_ready", s_ready, 1);
      run_beats(0, 32, 31, st);
      chk("b2b_first_beat_stall", st, 0);
      drain("b2b");

`ifdef CONV_WGT_WR_EN
      // Weight write during ACC is ignored
      wr_all(1, 0);
      wr_w(5, (wm[5] + 1) % 16 == 9 ? 8 : wm[5] == 9 ? 4 : wm[5], 1'b1);
      fill(32, 0, 1);
      run_beats(0, 10, -1, st);
      chk("acc_busy", busy, 1);
      wr_w(5, 9, 1'b0);
      run_beats(10, 22, 31, st);
      drain("wr_in_acc");
      // Same write in IDLE takes effect on the next frame
      wr_w(5, 9, 1'b1);
      run_beats(0, 32, 31, st);
      drain("wr_in_idle");
      // Write to W[0] together with a first beat: the beat uses the old W[0]
      fill(32, 1, 0);
      fd[0]    = 4'd5;
      wgt_we   = 1'b1;
      wgt_addr = '0;
      wgt_data = DW'((wm[0] + 7) % 16);
      run_beats(0, 32, 31, st);
      wgt_we = 1'b0;
      wm[0]  = (wm[0] + 7) % 16;
      drain("wr_with_beat");
      fill(32, 1, 0);
      run_beats(0, 32, 31, st);
      drain("wr_with_beat_next");
`endif

      // Reset mid-frame (after element 17)
      fill(32, 1, 0);
      run_beats(0, 17, -1, st);
      chk("mid_busy", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_m_valid", m_valid, 0);
      chk("mid_rst_busy",    busy,    0);
      chk("mid_rst_s_ready", s_ready, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      fill(32, 1, 0);
      run_beats(0, 32, 31, st);
      drain("after_rst");
`ifdef CONV_WGT_WR_EN
      wr_all(1, 0);
      fill(32, 1, 0);
      run_beats(0, 32, 31, st);
      drain("after_rst_wr");
`endif

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_seq_ctrl.md
# conv_seq_ctrl

Sequencing controller for the 2-channel 4x4 (32-tap) 3D convolution.
- Accepts one 4-bit IFM element per cycle over a valid/ready stream and multiplies it by its tap weight.
- Accumulates one 13-bit OFM value per 32-element frame and returns it over a valid/ready result port.
- Holds the tap weights in an internal register file, loadable from a configuration port.
- Sits between the IFM fetch stage and the OFM writeback: one MAC shared over 32 cycles instead of 32 parallel multipliers.

## Interface
Parameters:
- N_TAP, 32, elements per frame (2 channels x 4 x 4)
- DW, 4, IFM and weight width
- OW, 13, OFM width (15*15*32 = 7200 < 8192, never overflows)
- AW, 5, tap index / weight address width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  IFM element valid
- s_ready  out  1  controller can accept an element
- s_data  in  DW  IFM element, order ch0 row0 col0 .. ch1 row3 col3
- s_last  in  1  final element of frame
- m_valid  out  1  OFM result valid
- m_ready  in  1  downstream accepts result
- m_data  out  OW  OFM result
- busy  out  1  frame in progress (state != IDLE)
- err_len  out  1  one-cycle pulse: frame length error
- wgt_we  in  1  weight write strobe (CONV_WGT_WR_EN only)
- wgt_addr  in  AW  weight index 0..31 (CONV_WGT_WR_EN only)
- wgt_data  in  DW  weight value (CONV_WGT_WR_EN only)

## Operation
- Beat = cycle with s_valid && s_ready.
- FSM states: IDLE, ACC, OUT.
- IDLE:
  - s_ready=1.
  - Beat loads acc = s_data*W[0] and idx = 1.
  - Goes to ACC, or to OUT if s_last is set on that beat.
- ACC:
  - s_ready=1.
  - Each beat: acc += s_data*W[idx], idx++.
  - Frame ends on the beat with idx==31 or with s_last=1, whichever comes first. State goes to OUT.
- OUT:
  - s_ready=0, m_valid=1, m_data=acc.
  - Goes to IDLE on m_ready.
- Products are DW x DW unsigned (8 bits), zero-extended to OW. The accumulator is OW bits, unsigned.
- Length check, pulsed on the cycle after the ending beat:
  - err_len=1 if s_last=1 with idx<31 (short frame). The partial sum is still output.
  - err_len=1 if idx==31 with s_last=0 (long frame). The frame closes at 32 elements; the next element starts a new frame.
- Weight writes:
  - Accepted only in IDLE; W[wgt_addr] <= wgt_data.
  - Ignored in ACC and OUT, so weights stay stable for the whole frame.
  - A write and a beat in the same IDLE cycle: the beat uses the old W[0]; the write takes effect next cycle.
- s_valid with s_ready=0 (OUT): the element is not consumed. Upstream holds it.

## Timing
- Reset values: s_ready=0 during reset, then 1 in IDLE. m_valid=0, m_data=0, busy=0, err_len=0, state=IDLE, idx=0, acc=0.
- Weights reset to 0 (with macro) or to DEF_WGT (without macro).
- Latency: m_valid rises on the cycle after the ending beat.
- m_data and m_valid are registered and held stable until m_ready.
- Throughput: minimum 33 cycles per 32-element frame (32 beats plus 1 OUT cycle with m_ready=1).
- Back-to-back: the first beat of the next frame can be accepted on the cycle after the OUT handshake.
- busy is high from the cycle after the first beat until the OUT handshake.
- Reset asserted mid-frame: immediate return to reset values; the partial accumulation is discarded.

## Configuration
- CONV_WGT_WR_EN defined:
  - wgt_we, wgt_addr and wgt_data ports exist.
  - The 32x4 weight register file is writable and resets to 0.
- Not defined:
  - Those three ports are absent.
  - Weights are the constant set 6,14,13,10,10,14,3,4,0,6,7,9,11,12,6,3,2,1,5,8,7,13,1,8,7,12,13,10,10,9,7,7 (index 0..31).
  - No weight registers are synthesized.

## Test plan
- Basic sum (macro on): write all weights 1, send 32 elements of value 1 with s_last on beat 32 -> m_valid the next cycle, m_data=32, err_len=0.
- Max value: all weights 15, all data 15 -> m_data=7200, no overflow.
- Short frame: s_last on beat 10 with data=2 and weights=3 -> m_data=60, err_len pulse one cycle, FSM returns to IDLE after handshake.
- Backpressure:
  - Hold m_ready=0 for 5 cycles in OUT -> m_data stable, s_ready=0, offered element not consumed.
  - Then complete the handshake -> the next frame starts one cycle later.
- Weight write during ACC: write W[5]=9 mid-frame -> ignored, result uses the old weight. The same write in IDLE then takes effect on the next frame.
- Reset mid-frame: assert rst after beat 17 -> m_valid=0, busy=0, idx=0. A new full frame then produces the correct sum.
